sobel_frame_ctrl: RTL and testbench
===================================

Name: sobel_frame_ctrl

Overview:
Frame-level sequencer for the Sobel datapath. On start it walks every interior pixel of an IMG_W x IMG_H frame in raster order. For each pixel it fetches the 72-bit 3x3 window from frame memory, hands the window to the Sobel core, and writes the 8-bit result to result memory at a linear index. It sits between the frame/line memory, the Sobel core and the result store. It replaces bench-driven sequencing for a 640x480 frame, which produces 638*478 = 304964 results.

Parameters:
IMG_W, 640, frame width in pixels (>=3)
IMG_H, 480, frame height in pixels (>=3)
ADDR_W, 19, width of read address and write index
TIMEOUT, 255, maximum wait cycles for win_valid or core_valid before error

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse that begins a frame; ignored unless idle
abort  in  1  one-cycle pulse that stops the frame at the next step
busy  out  1  high from the accepted start until done
done  out  1  one-cycle pulse at frame end (normal end, abort or error)
err  out  1  sticky timeout flag; cleared by the next accepted start
rd_en  out  1  one-cycle window request
rd_addr  out  ADDR_W  raster address of the window centre, r*IMG_W+c
win_data  in  72  3x3 window from memory; p00 in [71:64] ... p22 in [7:0]
win_valid  in  1  window data valid; arrives 1..TIMEOUT cycles after rd_en
core_in  out  72  window presented to the Sobel core
core_strobe  out  1  one-cycle core launch
core_out  in  8  core result
core_valid  in  1  result valid; arrives 1..TIMEOUT cycles after core_strobe
wr_en  out  1  one-cycle result write
wr_idx  out  ADDR_W  linear result index, (r-1)*(IMG_W-2)+(c-1)
wr_data  out  8  result byte
px_count  out  ADDR_W  number of results written in the current frame

Behaviour:
- Reset (reset=0, asynchronous): state IDLE.
  - Outputs busy, done, err, rd_en, core_strobe and wr_en are 0.
  - rd_addr, core_in, wr_idx, wr_data and px_count are 0.
  - Internal row counter r=1, column counter c=1, wait counter 0.
  - Reset may assert mid-frame: all activity stops immediately and no further writes occur.
- States: IDLE, REQ, WAIT_WIN, FEED, WAIT_RES, WRITE, NEXT, FIN.
- IDLE:
  - On start, set r=1, c=1, px_count=0, err=0, busy=1, then go to REQ.
  - start while busy has no effect.
- REQ: drive rd_en=1 with rd_addr=r*IMG_W+c for exactly one cycle, clear the wait counter, go to WAIT_WIN.
- WAIT_WIN:
  - On win_valid, register win_data into core_in and go to FEED.
  - Otherwise increment the wait counter; when it reaches TIMEOUT, set err=1 and go to FIN.
- FEED: drive core_strobe=1 for one cycle with core_in stable, clear the wait counter, go to WAIT_RES. core_in holds until the next FEED.
- WAIT_RES:
  - On core_valid, register core_out into wr_data and go to WRITE.
  - Timeout rule is the same as WAIT_WIN.
- WRITE: drive wr_en=1 for one cycle with wr_idx=(r-1)*(IMG_W-2)+(c-1). px_count increments in the same edge. Go to NEXT.
- NEXT: advance the counters.
  - If c<IMG_W-2: c=c+1, go to REQ.
  - Else if r<IMG_H-2: c=1, r=r+1, go to REQ (row wrap).
  - Else go to FIN (last pixel r=IMG_H-2, c=IMG_W-2).
- FIN: done=1 for one cycle, busy=0, go to IDLE.
- Abort:
  - Sampled in every busy state; it takes effect at the next REQ decision, so the current pixel finishes through WRITE, then the block goes to FIN.
  - An abort in IDLE is ignored.
  - Abort and start in the same idle cycle: start wins.
- Address arithmetic:
  - rd_addr and wr_idx are computed at ADDR_W width and are never negative.
  - Parameters must satisfy IMG_W*IMG_H <= 2^ADDR_W.
- Stray inputs: win_valid or core_valid outside its wait state is ignored.
- Minimum cost per pixel: 6 cycles with 1-cycle memory and core latency. Frame end is marked by px_count = (IMG_W-2)*(IMG_H-2) together with done.

Test Plan:
- Reset, then start with 1-cycle memory and core models on a 640x480 frame -> 304964 wr_en pulses; first rd_addr=641 with wr_idx=0; last rd_addr=306558 with wr_idx=304963; one done pulse; err=0.
- IMG_W=5, IMG_H=4, core echoing the centre byte -> wr_idx sequence 0..5 and rd_addr sequence 6,7,8,11,12,13 (row wrap checked); px_count=6 at done.
- Memory withholds win_valid for TIMEOUT cycles on pixel 3 -> err=1, done pulse, no wr_en for pixel 3, px_count=2; the next start clears err.
- Abort pulsed during WAIT_RES of pixel 10 -> pixel 10 is written (wr_idx=9), no rd_en afterwards, done pulse, px_count=10.
- reset driven low mid-frame during WRITE -> all outputs 0 asynchronously; after release, start re-runs from rd_addr=IMG_W+1.
- start pulsed while busy, and stray core_valid in WAIT_WIN -> no restart, no extra write, sequence unchanged.

Source files
------------

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for the Sobel datapath: walks every interior pixel in raster
// order, fetching a 3x3 window, launching the core and storing each result.
module sobel_frame_ctrl #(
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int ADDR_W  = 19,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [71:0]       win_data,
  input  logic              win_valid,
  output logic [71:0]       core_in,
  output logic              core_strobe,
  input  logic [7:0]        core_out,
  input  logic              core_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_idx,
  output logic [7:0]        wr_data,
  output logic [ADDR_W-1:0] px_count
);

  localparam int CW = $clog2(IMG_W + 1);
  localparam int RW = $clog2(IMG_H + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0]     C_FIRST    = CW'(1);
  localparam logic [CW-1:0]     C_LAST     = CW'(IMG_W - 2);
  localparam logic [RW-1:0]     R_FIRST    = RW'(1);
  localparam logic [RW-1:0]     R_LAST     = RW'(IMG_H - 2);
  localparam logic [ADDR_W-1:0] ADDR_FIRST = ADDR_W'(IMG_W + 1);
  localparam logic [TW-1:0]     WAIT_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_WIN,
    FEED,
    WAIT_RES,
    WRITE,
    NEXT,
    FIN
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [TW-1:0] wait_cnt;
  logic          abort_pend;
  logic          abort_now;

  assign abort_now   = abort_pend | abort;
  assign busy        = (state != IDLE) && (state != FIN);
  assign done        = (state == FIN);
  assign rd_en       = (state == REQ);
  assign core_strobe = (state == FEED);
  assign wr_en       = (state == WRITE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = REQ;
        end
      end
      REQ: state_nxt = WAIT_WIN;
      WAIT_WIN: begin
        if (win_valid) begin
          state_nxt = FEED;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt = FIN;
        end
      end
      FEED: state_nxt = WAIT_RES;
      WAIT_RES: begin
        if (core_valid) begin
          state_nxt = WRITE;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt = FIN;
        end
      end
      WRITE: state_nxt = NEXT;
      NEXT: begin
        if (abort_now) begin
          state_nxt = FIN;
        end else if ((col < C_LAST) || (row < R_LAST)) begin
          state_nxt = REQ;
        end else begin
          state_nxt = FIN;
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // rd_addr and wr_idx are stepped incrementally rather than multiplied out;
  // a row wrap moves the centre from column IMG_W-2 to column 1 of the next row.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row        <= R_FIRST;
      col        <= C_FIRST;
      wait_cnt   <= '0;
      abort_pend <= 1'b0;
      err        <= 1'b0;
      rd_addr    <= '0;
      core_in    <= '0;
      wr_idx     <= '0;
      wr_data    <= '0;
      px_count   <= '0;
    end else begin
      if (busy && abort) begin
        abort_pend <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            row        <= R_FIRST;
            col        <= C_FIRST;
            px_count   <= '0;
            err        <= 1'b0;
            abort_pend <= 1'b0;
            rd_addr    <= ADDR_FIRST;
            wr_idx     <= '0;
          end
        end
        REQ: wait_cnt <= '0;
        WAIT_WIN: begin
          if (win_valid) begin
            core_in <= win_data;
          end else if (wait_cnt == WAIT_LAST) begin
            err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        FEED: wait_cnt <= '0;
        WAIT_RES: begin
          if (core_valid) begin
            wr_data <= core_out;
          end else if (wait_cnt == WAIT_LAST) begin
            err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        WRITE: px_count <= px_count + ADDR_W'(1);
        NEXT: begin
          if (!abort_now) begin
            if (col < C_LAST) begin
              col     <= col + CW'(1);
              rd_addr <= rd_addr + ADDR_W'(1);
              wr_idx  <= wr_idx + ADDR_W'(1);
            end else if (row < R_LAST) begin
              col     <= C_FIRST;
              row     <= row + RW'(1);
              rd_addr <= rd_addr + ADDR_W'(3);
              wr_idx  <= wr_idx + ADDR_W'(1);
            end
          end
        end
        FIN: abort_pend <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Directed bench for sobel_frame_ctrl on a 6x6 frame (16 interior pixels) with
// latency-configurable memory and core responders.
module tb_sobel_frame_ctrl;

  localparam int W    = 6;
  localparam int H    = 6;
  localparam int AW   = 19;
  localparam int TO   = 8;
  localparam int NPIX = (W - 2) * (H - 2);

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic          busy;
  logic          done;
  logic          err;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [71:0]   win_data;
  logic          win_valid;
  logic [71:0]   core_in;
  logic          core_strobe;
  logic [7:0]    core_out;
  logic          core_valid;
  logic          core_valid_m;
  logic          core_stray;
  logic          wr_en;
  logic [AW-1:0] wr_idx;
  logic [7:0]    wr_data;
  logic [AW-1:0] px_count;

  typedef struct {
    int md;
    int cd;
    int hold_m;
    int hold_c;
    int abort_at;
    int exp_wr;
    int exp_rd;
    int exp_err;
  } vec_t;

  vec_t vecs [6];

  int checks = 0;
  int errors = 0;
  int mem_delay = 1, core_delay = 1, mem_hold_at = -1, core_hold_at = -1;
  int mem_cnt = 0, core_cnt = 0;
  int rd_base = 0, st_base = 0, wr_base = 0, done_base = 0;
  int done_cnt = 0;
  logic [AW-1:0] px_at_done;
  logic          err_at_done;
  logic          busy_at_done;

  logic [AW-1:0] rd_q [$];
  logic [71:0]   st_q [$];
  logic [AW-1:0] wi_q [$];
  logic [7:0]    wd_q [$];

  assign core_valid = core_valid_m | core_stray;

  sobel_frame_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .busy(busy), .done(done), .err(err),
    .rd_en(rd_en), .rd_addr(rd_addr), .win_data(win_data), .win_valid(win_valid),
    .core_in(core_in), .core_strobe(core_strobe), .core_out(core_out), .core_valid(core_valid),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .px_count(px_count)
  );

  always #5 clk = ~clk;

  function automatic logic [71:0] win_of(input int a);
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 9; i++) begin
      w[71 - 8 * i -: 8] = 8'(a) ^ 8'(17 * i);
    end
    return w;
  endfunction

  function automatic int exp_addr(input int k);
    return (1 + k / (W - 2)) * W + 1 + k % (W - 2);
  endfunction

  // Memory responder: window for the latched address after mem_delay cycles.
  always @(posedge clk) begin
    win_valid <= 1'b0;
    if (rd_en && (rd_q.size() - 1 - rd_base) != mem_hold_at) begin
      win_data <= win_of(int'(rd_addr));
      if (mem_delay <= 1) win_valid <= 1'b1;
      else mem_cnt <= mem_delay - 1;
    end else if (mem_cnt > 0) begin
      mem_cnt <= mem_cnt - 1;
      if (mem_cnt == 1) win_valid <= 1'b1;
    end
  end

  // Core responder echoes the window centre byte.
  always @(posedge clk) begin
    core_valid_m <= 1'b0;
    if (core_strobe && (st_q.size() - 1 - st_base) != core_hold_at) begin
      core_out <= core_in[39:32];
      if (core_delay <= 1) core_valid_m <= 1'b1;
      else core_cnt <= core_delay - 1;
    end else if (core_cnt > 0) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1) core_valid_m <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rd_en) rd_q.push_back(rd_addr);
    if (core_strobe) st_q.push_back(core_in);
    if (wr_en) begin
      wi_q.push_back(wr_idx);
      wd_q.push_back(wr_data);
    end
    if (done) begin
      done_cnt++;
      px_at_done   = px_count;
      err_at_done  = err;
      busy_at_done = busy;
    end
  end

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_win(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, " busy"}, int'(busy), 0);
    check_output({tag, " done"}, int'(done), 0);
    check_output({tag, " err"}, int'(err), 0);
    check_output({tag, " rd_en"}, int'(rd_en), 0);
    check_output({tag, " core_strobe"}, int'(core_strobe), 0);
    check_output({tag, " wr_en"}, int'(wr_en), 0);
    check_output({tag, " rd_addr"}, int'(rd_addr), 0);
    check_win({tag, " core_in"}, core_in, 72'h0);
    check_output({tag, " wr_idx"}, int'(wr_idx), 0);
    check_output({tag, " wr_data"}, int'(wr_data), 0);
    check_output({tag, " px_count"}, int'(px_count), 0);
  endtask

  task automatic set_models(input int md, input int cd, input int hm, input int hc);
    mem_delay    = md;
    core_delay   = cd;
    mem_hold_at  = hm;
    core_hold_at = hc;
    rd_base      = rd_q.size();
    st_base      = st_q.size();
    wr_base      = wi_q.size();
    done_base    = done_cnt;
  endtask

  task automatic run_start(input bit with_abort);
    @(posedge clk); #1;
    start = 1'b1;
    abort = with_abort;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    check_output("busy after start", int'(busy), 1);
    check_output("err after start", int'(err), 0);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_cnt == done_base && n < 5000) begin
      @(negedge clk); #1;
      n++;
    end
    check_output("done seen", int'(done_cnt != done_base), 1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input vec_t v);
    int nw, nr, ns;
    nw = wi_q.size() - wr_base;
    nr = rd_q.size() - rd_base;
    ns = st_q.size() - st_base;
    check_output("done pulses", done_cnt - done_base, 1);
    check_output("write count", nw, v.exp_wr);
    check_output("read count", nr, v.exp_rd);
    check_output("px_count at done", int'(px_at_done), v.exp_wr);
    check_output("err at done", int'(err_at_done), v.exp_err);
    check_output("busy at done", int'(busy_at_done), 0);
    check_output("busy idle", int'(busy), 0);
    for (int k = 0; k < nr && k < v.exp_rd; k++)
      check_output($sformatf("rd_addr[%0d]", k), int'(rd_q[rd_base + k]), exp_addr(k));
    for (int k = 0; k < ns && k < v.exp_wr; k++)
      check_win($sformatf("core_in[%0d]", k), st_q[st_base + k], win_of(exp_addr(k)));
    for (int k = 0; k < nw && k < v.exp_wr; k++) begin
      check_output($sformatf("wr_idx[%0d]", k), int'(wi_q[wr_base + k]), k);
      check_output($sformatf("wr_data[%0d]", k), int'(wd_q[wr_base + k]),
                   (exp_addr(k) & 255) ^ 'h44);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    int n;
    set_models(v.md, v.cd, v.hold_m, v.hold_c);
    run_start(1'b0);
    if (v.abort_at >= 0) begin
      n = 0;
      while ((st_q.size() - st_base) <= v.abort_at && n < 5000) begin
        @(negedge clk); #1;
        n++;
      end
      @(posedge clk); #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
    end
    wait_done();
    check_frame(v);
  endtask

  initial begin
    int n;
    int nwr;
    vecs[0] = '{1, 1, -1, -1, -1, NPIX, NPIX, 0};
    vecs[1] = '{3, 2, -1, -1, -1, NPIX, NPIX, 0};
    vecs[2] = '{1, 1, 2, -1, -1, 2, 3, 1};
    vecs[3] = '{1, 3, -1, -1, 9, 10, 10, 0};
    vecs[4] = '{TO, TO, -1, -1, -1, NPIX, NPIX, 0};
    vecs[5] = '{1, 1, -1, 0, -1, 0, 1, 1};

    reset = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    core_stray = 1'b0;
    #2;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 6; i++) begin
      $display("[TB] vector %0d", i);
      apply_stimulus(vecs[i]);
    end

    // Reset during WRITE of the fourth pixel, then a clean rerun.
    $display("[TB] mid-frame reset");
    set_models(1, 1, -1, -1);
    run_start(1'b0);
    n = 0;
    while (!(wr_en && (wi_q.size() - wr_base) == 4) && n < 5000) begin
      @(negedge clk); #1;
      n++;
    end
    reset = 1'b0;
    #1;
    check_all_zero("mid reset");
    nwr = wi_q.size();
    repeat (4) @(posedge clk);
    #1;
    check_output("writes during reset", wi_q.size() - nwr, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (6) @(posedge clk);
    apply_stimulus(vecs[0]);

    // Start+abort together from idle, then start and stray core_valid in WAIT_WIN.
    $display("[TB] start while busy and stray core_valid");
    set_models(3, 1, -1, -1);
    run_start(1'b1);
    n = 0;
    while ((rd_q.size() - rd_base) < 3 && n < 5000) begin
      @(negedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    start = 1'b1;
    core_stray = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    core_stray = 1'b0;
    wait_done();
    check_frame(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
